erx_distributor: RTL and testbench

Receive-side counterpart of the TX arbitration path. Accepts one eMesh transaction per cycle from the RX protocol block and routes it to one of three FIFOs: host write (emwr), read request (emrq) or read response (emrr). Raises per-class wait signals back to the RX protocol block, and absorbs one in-flight transaction in a skid buffer so nothing is lost while the wait propagates.

---
 rtl/erx_distributor.sv | 155 +++++++++++++++
 tb/tb_erx_distributor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/erx_distributor.sv
// RX-side distributor: routes eMesh transactions to write, read-request
// and read-response FIFOs, with a one-entry skid buffer behind the output
// register and registered per-class waits back to the RX protocol block.
// Ports: rx_lclk_par/reset, erx_* transaction in, em*_full in,
//        em*_wr_en + shared fifo_* fields out, erx_*_wait, erx_overflow.
module erx_distributor #(
  parameter logic [11:0] C_READ_TAG_ADDR = 12'h810
) (
  input  logic        rx_lclk_par,
  input  logic        reset,
  input  logic        erx_access,
  input  logic        erx_write,
  input  logic [1:0]  erx_datamode,
  input  logic [3:0]  erx_ctrlmode,
  input  logic [31:0] erx_dstaddr,
  input  logic [31:0] erx_srcaddr,
  input  logic [31:0] erx_data,
  input  logic        emwr_full,
  input  logic        emrq_full,
  input  logic        emrr_full,
  output logic        emwr_wr_en,
  output logic        emrq_wr_en,
  output logic        emrr_wr_en,
  output logic        fifo_write,
  output logic [1:0]  fifo_datamode,
  output logic [3:0]  fifo_ctrlmode,
  output logic [31:0] fifo_dstaddr,
  output logic [31:0] fifo_srcaddr,
  output logic [31:0] fifo_data,
  output logic        erx_wr_wait,
  output logic        erx_rd_wait,
  output logic        erx_overflow
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] CLS_WR = 2'd0;
  localparam logic [1:0] CLS_RQ = 2'd1;
  localparam logic [1:0] CLS_RR = 2'd2;

  typedef struct packed {
    logic [1:0]  cls;
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } ent_t;

  state_t state_q, state_d;
  ent_t   out_q, out_d;
  ent_t   skid_q, skid_d;
  ent_t   in_ent;
  logic   ovf_q, ovf_d;
  logic   wr_wait_q, wr_wait_d;
  logic   rd_wait_q, rd_wait_d;
  logic   out_valid;
  logic   pop;

  // Class is decided once at capture and travels with the entry.
  always_comb begin
    in_ent          = '0;
    in_ent.write    = erx_write;
    in_ent.datamode = erx_datamode;
    in_ent.ctrlmode = erx_ctrlmode;
    in_ent.dstaddr  = erx_dstaddr;
    in_ent.srcaddr  = erx_srcaddr;
    in_ent.data     = erx_data;
    if (!erx_write)
      in_ent.cls = CLS_RQ;
    else if (erx_dstaddr[31:20] == C_READ_TAG_ADDR)
      in_ent.cls = CLS_RR;
    else
      in_ent.cls = CLS_WR;
  end

  assign out_valid = (state_q != EMPTY);

  assign emwr_wr_en = out_valid & (out_q.cls == CLS_WR) & ~emwr_full;
  assign emrq_wr_en = out_valid & (out_q.cls == CLS_RQ) & ~emrq_full;
  assign emrr_wr_en = out_valid & (out_q.cls == CLS_RR) & ~emrr_full;
  assign pop = emwr_wr_en | emrq_wr_en | emrr_wr_en;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (erx_access) begin
          out_d   = in_ent;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (pop) begin
          if (erx_access) out_d = in_ent;
          else state_d = EMPTY;
        end else if (erx_access) begin
          skid_d  = in_ent;
          state_d = FULL;
        end
      end
      FULL: begin
        // Skid drains first; a same-cycle access refills it so order holds.
        if (pop) begin
          out_d = skid_q;
          if (erx_access) skid_d = in_ent;
          else state_d = HOLD;
        end else if (erx_access) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign wr_wait_d = emwr_full | emrr_full | (state_d == FULL);
  assign rd_wait_d = emrq_full | (state_d == FULL);

  always_ff @(posedge rx_lclk_par or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      ovf_q     <= 1'b0;
      wr_wait_q <= 1'b0;
      rd_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      ovf_q     <= ovf_d;
      wr_wait_q <= wr_wait_d;
      rd_wait_q <= rd_wait_d;
    end
  end

  assign fifo_write    = out_q.write;
  assign fifo_datamode = out_q.datamode;
  assign fifo_ctrlmode = out_q.ctrlmode;
  assign fifo_dstaddr  = out_q.dstaddr;
  assign fifo_srcaddr  = out_q.srcaddr;
  assign fifo_data     = out_q.data;
  assign erx_wr_wait   = wr_wait_q;
  assign erx_rd_wait   = rd_wait_q;
  assign erx_overflow  = ovf_q;

endmodule

// File: tb/tb_erx_distributor.sv
// Directed bench for erx_distributor: vector table for routing, latency
// and back-pressure, plus hand sequences for overflow and async reset.
module tb_erx_distributor;

  logic        clk = 1'b0;
  logic        reset;
  logic        erx_access, erx_write;
  logic [1:0]  erx_datamode;
  logic [3:0]  erx_ctrlmode;
  logic [31:0] erx_dstaddr, erx_srcaddr, erx_data;
  logic        emwr_full, emrq_full, emrr_full;
  logic        emwr_wr_en, emrq_wr_en, emrr_wr_en;
  logic        fifo_write;
  logic [1:0]  fifo_datamode;
  logic [3:0]  fifo_ctrlmode;
  logic [31:0] fifo_dstaddr, fifo_srcaddr, fifo_data;
  logic        erx_wr_wait, erx_rd_wait, erx_overflow;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  erx_distributor dut (
    .rx_lclk_par  (clk),
    .reset        (reset),
    .erx_access   (erx_access),
    .erx_write    (erx_write),
    .erx_datamode (erx_datamode),
    .erx_ctrlmode (erx_ctrlmode),
    .erx_dstaddr  (erx_dstaddr),
    .erx_srcaddr  (erx_srcaddr),
    .erx_data     (erx_data),
    .emwr_full    (emwr_full),
    .emrq_full    (emrq_full),
    .emrr_full    (emrr_full),
    .emwr_wr_en   (emwr_wr_en),
    .emrq_wr_en   (emrq_wr_en),
    .emrr_wr_en   (emrr_wr_en),
    .fifo_write   (fifo_write),
    .fifo_datamode(fifo_datamode),
    .fifo_ctrlmode(fifo_ctrlmode),
    .fifo_dstaddr (fifo_dstaddr),
    .fifo_srcaddr (fifo_srcaddr),
    .fifo_data    (fifo_data),
    .erx_wr_wait  (erx_wr_wait),
    .erx_rd_wait  (erx_rd_wait),
    .erx_overflow (erx_overflow)
  );

  // en / full ordering is {wr, rq, rr}
  typedef struct {
    logic        acc;
    logic        wr;
    logic [31:0] dst;
    logic [31:0] data;
    logic [2:0]  full;
    logic [2:0]  en;
    logic [31:0] edata;
    logic        ww;
    logic        rw;
    logic        ovf;
  } vec_t;

  localparam logic [31:0] A_WR = 32'h8000_0000;
  localparam logic [31:0] A_RR = 32'h8100_0040;
  localparam logic [31:0] A_RQ = 32'h0000_1000;

  vec_t v[17];

  function automatic vec_t mk(logic acc, logic wr, logic [31:0] dst,
                              logic [31:0] data, logic [2:0] full,
                              logic [2:0] en, logic [31:0] edata,
                              logic ww, logic rw, logic ovf);
    vec_t r;
    r.acc = acc; r.wr = wr; r.dst = dst; r.data = data; r.full = full;
    r.en = en; r.edata = edata; r.ww = ww; r.rw = rw; r.ovf = ovf;
    return r;
  endfunction

  task automatic drive(logic acc, logic wr, logic [31:0] dst,
                       logic [31:0] data, logic [2:0] full);
    erx_access   = acc;
    erx_write    = wr;
    erx_dstaddr  = dst;
    erx_data     = data;
    erx_srcaddr  = data ^ 32'h5A5A_0000;
    erx_datamode = 2'b10;
    erx_ctrlmode = 4'h3;
    {emwr_full, emrq_full, emrr_full} = full;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] obs(logic mask_data);
    logic [31:0] d;
    d = mask_data ? 32'h0 : fifo_data;
    return {24'h0, emwr_wr_en, emrq_wr_en, emrr_wr_en, d,
            erx_wr_wait, erx_rd_wait, erx_overflow};
  endfunction

  function automatic logic [63:0] want(logic [2:0] en, logic [31:0] d,
                                       logic ww, logic rw, logic ovf);
    return {24'h0, en, d, ww, rw, ovf};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // basic routing and one-cycle latency
    v[0]  = mk(1, 1, A_WR, 32'hDEAD_BEEF, 3'b000, 3'b000, 0, 0, 0, 0);
    v[1]  = mk(0, 0, 0, 0, 3'b000, 3'b100, 32'hDEAD_BEEF, 0, 0, 0);
    v[2]  = mk(1, 1, A_RR, 32'h11, 3'b000, 3'b000, 0, 0, 0, 0);
    v[3]  = mk(1, 0, A_RQ, 32'h22, 3'b000, 3'b001, 32'h11, 0, 0, 0);
    v[4]  = mk(0, 0, 0, 0, 3'b000, 3'b010, 32'h22, 0, 0, 0);
    v[5]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    // back-to-back RQ, WR, RR stream
    v[6]  = mk(1, 0, A_RQ, 32'h31, 3'b000, 3'b000, 0, 0, 0, 0);
    v[7]  = mk(1, 1, A_WR, 32'h32, 3'b000, 3'b010, 32'h31, 0, 0, 0);
    v[8]  = mk(1, 1, 32'h8100_0000, 32'h33, 3'b000, 3'b100, 32'h32,
               0, 0, 0);
    v[9]  = mk(0, 0, 0, 0, 3'b000, 3'b001, 32'h33, 0, 0, 0);
    v[10] = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    // write FIFO full, two writes go to output then skid
    v[11] = mk(1, 1, A_WR, 32'h1, 3'b100, 3'b000, 0, 0, 0, 0);
    v[12] = mk(1, 1, A_WR, 32'h2, 3'b100, 3'b000, 0, 1, 0, 0);
    v[13] = mk(0, 0, 0, 0, 3'b100, 3'b000, 0, 1, 1, 0);
    v[14] = mk(0, 0, 0, 0, 3'b000, 3'b100, 32'h1, 1, 1, 0);
    v[15] = mk(0, 0, 0, 0, 3'b000, 3'b100, 32'h2, 0, 0, 0);
    v[16] = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", obs(0), want(3'b000, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(v[i].acc, v[i].wr, v[i].dst, v[i].data, v[i].full);
      #4;
      chk($sformatf("vec%0d", i), obs(v[i].en == 3'b000),
          want(v[i].en, v[i].en == 3'b000 ? 32'h0 : v[i].edata,
               v[i].ww, v[i].rw, v[i].ovf));
      cyc();
    end

    // overflow: read blocked in output, write in skid, third dropped
    drive(1, 0, A_RQ, 32'h51, 3'b010);
    cyc();
    drive(1, 1, A_WR, 32'h52, 3'b010);
    #4;
    chk("ovf_blocked", obs(1), want(3'b000, 0, 0, 1, 0));
    cyc();
    drive(1, 1, A_WR, 32'h53, 3'b010);
    #4;
    chk("ovf_before", obs(1), want(3'b000, 0, 1, 1, 0));
    cyc();
    drive(0, 0, 0, 0, 3'b000);
    #4;
    chk("ovf_head_rq", obs(0), want(3'b010, 32'h51, 1, 1, 1));
    cyc();
    #4;
    chk("ovf_then_wr", obs(0), want(3'b100, 32'h52, 0, 0, 1));
    cyc();
    #4;
    chk("ovf_sticky", obs(1), want(3'b000, 0, 0, 0, 1));
    cyc();

    // async reset while FULL
    drive(1, 1, A_WR, 32'h61, 3'b100);
    cyc();
    drive(1, 1, A_WR, 32'h62, 3'b100);
    cyc();
    drive(0, 0, 0, 0, 3'b100);
    #2;
    chk("full_pre_reset", obs(1), want(3'b000, 0, 1, 1, 1));
    reset = 1'b1;
    #1;
    chk("async_reset", obs(0), want(3'b000, 0, 0, 0, 0));
    cyc();
    reset = 1'b0;
    drive(0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("post_reset%0d", i), obs(0),
          want(3'b000, 0, 0, 0, 0));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
